// File: rtl/scu_exec_slice.sv
// Purpose: SCU decode + execute slice: control decoder, 32-bit ALU with Z/N flags, word data memory.
// Latency: decode, ALU and memory read are combinational (0 cycles); a store lands on the next rising edge.
// Backpressure: none; the slice consumes one instruction per cycle and never stalls the wrapper.
//
// Ports:
//   clock, rst_n           - rising-edge clock, async active-low reset (clears data memory only)
//   instr, pc              - instruction under execution and its address
//   rs_data, rt_data       - register-file read operands for rs / rt
//   reg_write .. alu_op    - decoded control signals consumed by WB and PC-select logic
//   alu_result, z, n       - ALU output and its zero / negative flags
//   mem_rdata              - data-memory word at rs_data (0 when the instruction does not read)
module scu_exec_slice #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        jump,
    output logic        jump_mem,
    output logic        mem_write,
    output logic        mem_read,
    output logic        branch_neg,
    output logic        branch_zero,
    output logic        save_pc,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_result,
    output logic        z,
    output logic        n,
    output logic [31:0] mem_rdata
);

    // ------------------------------------------------------------------
    // Opcodes and ALU operation encodings
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NEG  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b100;

    // Bundled control word; unpacked onto the individual output ports below.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       jump;
        logic       jump_mem;
        logic       mem_write;
        logic       mem_read;
        logic       branch_neg;
        logic       branch_zero;
        logic       save_pc;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]  opcode;
    logic [31:0] imm16_sext;
    logic [31:0] imm22_sext;
    logic        unused_rd;

    assign opcode     = instr[31:28];
    assign imm16_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm22_sext = {{10{instr[21]}}, instr[21:0]};
    // rd is consumed by the register-file write port in the wrapper, not here.
    assign unused_rd  = ^instr[27:22];

    // ------------------------------------------------------------------
    // Control decoder
    // ------------------------------------------------------------------
    ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OP_SVPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.save_pc   = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_LD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            OP_ST: begin
                ctrl.mem_write = 1'b1;
            end
            OP_ADD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_INC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_NEG: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_NEG;
            end
            OP_SUB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_BRZ: begin
                ctrl.branch_zero = 1'b1;
            end
            OP_JM: begin
                // Jump target is fetched from data memory, so the read strobe is needed too.
                ctrl.jump     = 1'b1;
                ctrl.jump_mem = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            OP_BRN: begin
                ctrl.branch_neg = 1'b1;
            end
            default: begin
                // OP_NOP and every undefined opcode: all controls stay low.
                ctrl = '0;
            end
        endcase
    end

    assign reg_write   = ctrl.reg_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign jump        = ctrl.jump;
    assign jump_mem    = ctrl.jump_mem;
    assign mem_write   = ctrl.mem_write;
    assign mem_read    = ctrl.mem_read;
    assign branch_neg  = ctrl.branch_neg;
    assign branch_zero = ctrl.branch_zero;
    assign save_pc     = ctrl.save_pc;
    assign alu_src     = ctrl.alu_src;
    assign alu_op      = ctrl.alu_op;

    // ------------------------------------------------------------------
    // Operand muxes and ALU
    // ------------------------------------------------------------------
    logic [31:0] opnd_a;
    logic [31:0] opnd_imm;
    logic [31:0] opnd_b;

    assign opnd_a   = ctrl.save_pc ? pc         : rs_data;
    assign opnd_imm = ctrl.save_pc ? imm22_sext : imm16_sext;
    assign opnd_b   = ctrl.alu_src ? opnd_imm   : rt_data;

    always_comb begin
        alu_result = '0;
        case (ctrl.alu_op)
            ALU_ADD:  alu_result = opnd_a + opnd_b;
            ALU_NEG:  alu_result = 32'd0 - opnd_a;
            ALU_SUB:  alu_result = opnd_a - opnd_b;
            ALU_PASS: alu_result = opnd_a;
            default:  alu_result = '0;
        endcase
    end

    assign z = (alu_result == 32'd0);
    assign n = alu_result[31];

    // ------------------------------------------------------------------
    // Data memory: word-indexed, upper address bits dropped so accesses wrap.
    // Reset clears the array asynchronously and, by holding the flops in
    // reset, also blocks any store issued while rst_n is low.
    // ------------------------------------------------------------------
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] mem_addr;

    assign mem_addr = rs_data[ADDR_W-1:0];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ctrl.mem_write) begin
            mem[mem_addr] <= rt_data;
        end
    end

    // Combinational read: a same-address store shows up only after its edge.
    assign mem_rdata = ctrl.mem_read ? mem[mem_addr] : 32'd0;

endmodule

// File: tb/tb_scu_exec_slice.sv
// Purpose: self-checking bench for scu_exec_slice against an opcode-level reference model.
// Latency: results checked 1 time unit after inputs change; stores checked on the following cycle.
// Backpressure: not applicable; one instruction is presented per clock cycle.
module tb_scu_exec_slice;

    logic        clock;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_write;
    logic        mem_to_reg;
    logic        jump;
    logic        jump_mem;
    logic        mem_write;
    logic        mem_read;
    logic        branch_neg;
    logic        branch_zero;
    logic        save_pc;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        z;
    logic        n;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Reference data memory, indexed by the low 8 address bits.
    logic [31:0] ref_mem [256];

    scu_exec_slice #(.DEPTH(256), .ADDR_W(8)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .instr       (instr),
        .pc          (pc),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .jump        (jump),
        .jump_mem    (jump_mem),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .branch_neg  (branch_neg),
        .branch_zero (branch_zero),
        .save_pc     (save_pc),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .z           (z),
        .n           (n),
        .mem_rdata   (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [21:0] imm);
        return {op, 6'd0, imm};
    endfunction

    // Control word order: reg_write mem_to_reg jump jump_mem mem_write mem_read
    //                     branch_neg branch_zero save_pc alu_src alu_op[2:0]
    function automatic logic [12:0] exp_ctrl(input logic [3:0] op);
        case (op)
            4'hF:    return 13'b1_0_0_0_0_0_0_0_1_1_100;
            4'hE:    return 13'b1_1_0_0_0_1_0_0_0_0_000;
            4'h3:    return 13'b0_0_0_0_1_0_0_0_0_0_000;
            4'h4:    return 13'b1_0_0_0_0_0_0_0_0_0_100;
            4'h5:    return 13'b1_0_0_0_0_0_0_0_0_1_100;
            4'h6:    return 13'b1_0_0_0_0_0_0_0_0_0_010;
            4'h7:    return 13'b1_0_0_0_0_0_0_0_0_0_001;
            4'h8:    return 13'b0_0_1_0_0_0_0_0_0_0_000;
            4'h9:    return 13'b0_0_0_0_0_0_0_1_0_0_000;
            4'hA:    return 13'b0_0_1_1_0_1_0_0_0_0_000;
            4'hB:    return 13'b0_0_0_0_0_0_1_0_0_0_000;
            default: return 13'b0;
        endcase
    endfunction

    // Architectural result of each instruction; non-arithmetic ones pass rs through.
    function automatic logic [31:0] exp_result(input logic [31:0] i, input logic [31:0] p,
                                                input logic [31:0] a, input logic [31:0] b);
        int signed s16;
        int signed s22;
        s16 = int'($signed(i[15:0]));
        s22 = int'($signed(i[21:0]));
        case (i[31:28])
            4'hF:    return p + 32'(s22);
            4'h4:    return a + b;
            4'h5:    return a + 32'(s16);
            4'h6:    return -a;
            4'h7:    return a - b;
            default: return a;
        endcase
    endfunction

    // Present one instruction mid-cycle, check all outputs, then let one edge pass.
    task automatic step(input string tag, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic [31:0] rd;
        @(negedge clock);
        instr   = i;
        pc      = p;
        rs_data = a;
        rt_data = b;
        #1;
        res = exp_result(i, p, a, b);
        rd  = (i[31:28] == 4'hE || i[31:28] == 4'hA) ? ref_mem[a[7:0]] : 32'd0;
        check({tag, ".ctrl"}, 32'({reg_write, mem_to_reg, jump, jump_mem, mem_write, mem_read,
                                   branch_neg, branch_zero, save_pc, alu_src, alu_op}),
              32'(exp_ctrl(i[31:28])));
        check({tag, ".res"},   alu_result, res);
        check({tag, ".z"},     32'(z), 32'(res == 32'd0));
        check({tag, ".n"},     32'(n), 32'(res[31]));
        check({tag, ".rdata"}, mem_rdata, rd);
        @(posedge clock);
        if (i[31:28] == 4'h3 && rst_n) ref_mem[a[7:0]] = b;
        #1;
    endtask

    initial begin
        logic [31:0] ri;
        logic [31:0] ra;
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        rst_n   = 1'b0;
        instr   = '0;
        pc      = '0;
        rs_data = '0;
        rt_data = '0;
        #12;
        rst_n = 1'b1;

        // Reset state: memory cleared, NOP decodes to all-zero controls.
        step("rst_ld0", mk(4'hE, 0), 0, 32'd0, 0);
        step("rst_ld255", mk(4'hE, 0), 0, 32'd255, 0);
        step("nop", mk(4'h0, 0), 0, 32'd11, 32'd3);

        // Arithmetic from the test plan, with literal cross-checks.
        step("add", mk(4'h4, 0), 0, 32'd7, 32'd5);
        step("sub", mk(4'h7, 0), 0, 32'd7, 32'd5);
        step("sub_neg", mk(4'h7, 0), 0, 32'd5, 32'd7);
        @(negedge clock);
        instr = mk(4'h7, 0); rs_data = 32'd5; rt_data = 32'd7;
        #1;
        check("sub_lit", alu_result, 32'hFFFF_FFFE);
        check("sub_lit_n", 32'(n), 32'd1);
        step("inc", mk(4'h5, 22'h00FFFF), 0, 32'd10, 32'd0);
        step("neg", mk(4'h6, 0), 0, 32'd3, 32'd0);
        step("neg_zero", mk(4'h6, 0), 0, 32'd0, 32'd99);
        step("svpc", mk(4'hF, 22'h3FFFFC), 32'h20, 32'd123, 32'd0);
        @(negedge clock);
        instr = mk(4'hF, 22'h3FFFFC); pc = 32'h20;
        #1;
        check("svpc_lit", alu_result, 32'h0000_001C);

        // Store / load, and read strobe gating.
        step("st4", mk(4'h3, 0), 0, 32'd4, 32'hDEAD_BEEF);
        step("ld4", mk(4'hE, 0), 0, 32'd4, 32'd0);
        @(negedge clock);
        instr = mk(4'hE, 0); rs_data = 32'd4;
        #1;
        check("ld4_lit", mem_rdata, 32'hDEAD_BEEF);
        step("add_no_read", mk(4'h4, 0), 0, 32'd4, 32'd0);

        // Address wrap: 0x104 aliases word 4.
        step("st_wrap", mk(4'h3, 0), 0, 32'h104, 32'h1234_5678);
        step("ld_wrap", mk(4'hE, 0), 0, 32'd4, 32'd0);
        step("jm_wrap", mk(4'hA, 0), 0, 32'h204, 32'd0);

        // Control-flow and undefined opcodes.
        step("j", mk(4'h8, 0), 0, 32'd1, 32'd2);
        step("brz", mk(4'h9, 0), 0, 32'd1, 32'd2);
        step("brn", mk(4'hB, 0), 0, 32'd1, 32'd2);
        step("undef1", mk(4'h1, 0), 0, 32'd1, 32'd2);
        step("undef2", mk(4'h2, 0), 0, 32'd1, 32'd2);
        step("undefC", mk(4'hC, 0), 0, 32'd1, 32'd2);
        step("undefD", mk(4'hD, 0), 0, 32'd1, 32'd2);

        // Asynchronous reset pulse with no clock edge in between.
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        step("ld_after_rst", mk(4'hE, 0), 0, 32'd4, 32'd0);

        // Store while held in reset must not land.
        rst_n = 1'b0;
        step("st_in_rst", mk(4'h3, 0), 0, 32'd9, 32'hCAFE_F00D);
        rst_n = 1'b1;
        step("ld_in_rst", mk(4'hE, 0), 0, 32'd9, 32'd0);

        // Randomized traffic; addresses kept small half the time so loads hit stores.
        for (int t = 0; t < 300; t++) begin
            ri = $urandom;
            ra = $urandom;
            if (ri[0]) ra = {$urandom_range(3, 0), 22'd0, 6'($urandom_range(15, 0))};
            step("rand", ri, $urandom, ra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scu_exec_slice.md
Name: scu_exec_slice

Overview:
Decode-plus-execute slice for the SCU ISA processor. It combines the main control decoder, the 32-bit ALU with Z/N flags, and the word-addressed data memory into one block. The pipeline wrapper supplies the instruction, its PC and both register-read operands. The block returns the control signals, the ALU result and flags, and the memory read data used by the WB and PC-select logic.

Parameters:
DEPTH, 256, number of 32-bit data-memory words
ADDR_W, 8, address bits used to index memory (log2 DEPTH)

Ports:
clock  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction; opcode [31:28], rd [27:22], rs [21:16], rt [15:10], imm16 [15:0], imm22 [21:0]
pc  in  32  address of instr
rs_data  in  32  register-file value of rs
rt_data  in  32  register-file value of rt
reg_write  out  1  write rd
mem_to_reg  out  1  WB selects mem_rdata
jump  out  1  unconditional PC redirect
jump_mem  out  1  jump target comes from memory
mem_write  out  1  store strobe
mem_read  out  1  load strobe
branch_neg  out  1  branch if N
branch_zero  out  1  branch if Z
save_pc  out  1  ALU A = pc, imm = imm22
alu_src  out  1  ALU B = immediate
alu_op  out  3  {add, neg, sub}
alu_result  out  32  ALU output
z  out  1  alu_result == 0
n  out  1  alu_result[31]
mem_rdata  out  32  data-memory read data

Behaviour:
- Decode is combinational from instr[31:28]. Signals not listed for an opcode are 0.
  - 0000 NOP: all controls 0.
  - 1111 SVPC: reg_write, save_pc, alu_src, alu_op=100. Result is rd = pc + sext(imm22).
  - 1110 LD: reg_write, mem_to_reg, mem_read. Result is rd = M[rs].
  - 0011 ST: mem_write. Effect is M[rs] = rt.
  - 0100 ADD: reg_write, alu_op=100. Result is rs + rt.
  - 0101 INC: reg_write, alu_src, alu_op=100. Result is rs + sext(imm16).
  - 0110 NEG: reg_write, alu_op=010. Result is -rs.
  - 0111 SUB: reg_write, alu_op=001. Result is rs - rt.
  - 1000 J: jump.
  - 1001 BRZ: branch_zero.
  - 1010 JM: jump, jump_mem, mem_read.
  - 1011 BRN: branch_neg.
  - All other opcodes: treated as NOP.
- Operand muxes:
  - A = save_pc ? pc : rs_data.
  - imm = save_pc ? sext(imm22) : sext(imm16).
  - B = alu_src ? imm : rt_data.
- ALU (combinational, 32-bit two's complement, carry/overflow discarded, wraps mod 2^32):
  - alu_op 100: A+B.
  - alu_op 010: 0-A.
  - alu_op 001: A-B.
  - alu_op 000: pass A.
  - Any other alu_op: 0.
  - z = (alu_result == 0); n = alu_result[31]. Both are combinational.
- Data memory:
  - Address is rs_data[ADDR_W-1:0], word-indexed; upper bits are ignored, so addresses wrap.
  - Write on rising clock edge when mem_write=1 and rst_n=1, storing rt_data.
  - Read is combinational: mem_rdata = mem_read ? M[addr] : 0.
  - Read-during-write to the same address returns the old word until the edge, then the new word.
- Reset:
  - rst_n low asynchronously clears every memory word to 0 and blocks writes.
  - Reset has no effect on the combinational outputs beyond the memory contents.
- Latency: decode/ALU/read are 0 cycles; a store is visible 1 cycle later.

Test Plan:
- ADD, rs_data=7, rt_data=5 -> reg_write=1, alu_op=100, alu_result=12, z=0, n=0. SUB with the same operands -> 2. SUB 5-7 -> 0xFFFFFFFE, n=1.
- INC, rs_data=10, imm16=0xFFFF -> alu_src=1, result=9. NEG, rs_data=3 -> 0xFFFFFFFD, n=1. NEG, rs_data=0 -> z=1.
- SVPC, pc=0x20, imm22=0x3FFFFC -> save_pc=1, alu_result=0x1C.
- ST, rs_data=4, rt_data=0xDEADBEEF, one clock edge; then LD, rs_data=4 -> mem_rdata=0xDEADBEEF, mem_to_reg=1. Same LD with mem_read=0 (e.g. ADD opcode) -> mem_rdata=0.
- Wrap/reset: ST to address 0x104 with DEPTH=256 -> LD at address 4 returns the stored value. Pulse rst_n low mid-run with no clock -> LD returns 0. ST with rst_n low -> no write.
- J/BRZ/JM/BRN/undefined opcode 0x1 -> exactly the listed single control bits (jump / branch_zero / jump+jump_mem+mem_read / branch_neg / none), reg_write=0, mem_write=0.
